// File: rtl/icache_way0_pkg.sv
// Shared state encodings, derived field widths and address-field helpers for the way0 fetch cache.
package icache_way0_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_REFILL = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  function automatic int off_w(input int words_per_line);
    return $clog2(words_per_line);
  endfunction

  function automatic int idx_w(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int tag_w(input int addr_w, input int lines, input int words_per_line);
    return addr_w - 2 - $clog2(lines) - $clog2(words_per_line);
  endfunction

  // Returns addr[lsb +: width], zero-extended; callers narrow to the field width.
  function automatic logic [63:0] addr_field(input logic [63:0] addr, input int lsb, input int width);
    return (addr >> lsb) & ((64'd1 << width) - 64'd1);
  endfunction

endpackage

// File: rtl/icache_way0_array.sv
// Flop-based valid/tag/data storage: combinational read, one word write per cycle, tag/valid write, flush-all.
module icache_way0_array
  import icache_way0_pkg::*;
#(
  parameter int LINES          = 16,
  parameter int WORDS_PER_LINE = 4,
  parameter int TAG_W          = 26,
  localparam int IDX_W         = idx_w(LINES),
  localparam int OFF_W         = off_w(WORDS_PER_LINE)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [IDX_W-1:0] rd_idx_i,
  input  logic [OFF_W-1:0] rd_off_i,
  output logic             rd_vld_o,
  output logic [TAG_W-1:0] rd_tag_o,
  output logic [31:0]      rd_word_o,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic [OFF_W-1:0] wr_off_i,
  input  logic [31:0]      wr_word_i,
  input  logic             tag_wr_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic             valid_set_i,
  input  logic             flush_i
);

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [31:0]      data_q [LINES][WORDS_PER_LINE];

  assign rd_vld_o  = valid_q[rd_idx_i];
  assign rd_tag_o  = tag_q[rd_idx_i];
  assign rd_word_o = data_q[rd_idx_i][rd_off_i];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q <= '0;
    end else if (flush_i) begin
      valid_q <= '0;
    end else if (tag_wr_i) begin
      valid_q[wr_idx_i] <= valid_set_i;
    end
  end

  // Tag and data contents are meaningless until valid is set, so they carry no reset.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      data_q[wr_idx_i][wr_off_i] <= wr_word_i;
    end
    if (tag_wr_i) begin
      tag_q[wr_idx_i] <= tag_i;
    end
  end

endmodule

// File: rtl/icache_way0.sv
// Direct-mapped way0 instruction cache: 1-cycle hit response, line refill over a word-beat memory port.
module icache_way0
  import icache_way0_pkg::*;
#(
  parameter int LINES          = 16,
  parameter int WORDS_PER_LINE = 4,
  parameter int ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              request_i,
  input  logic [ADDR_W-1:0] instAddr_i,
  input  logic              flush_i,
  output logic              dataOk_o,
  output logic [31:0]       inst_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_ack_i,
  input  logic [31:0]       mem_rdata_i,
  output logic              busy_o
);

  localparam int OFF_W = off_w(WORDS_PER_LINE);
  localparam int IDX_W = idx_w(LINES);
  localparam int TAG_W = tag_w(ADDR_W, LINES, WORDS_PER_LINE);

  logic [1:0]        state_q, state_d;
  logic [OFF_W-1:0]  beat_q, beat_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              dataok_q, dataok_d;
  logic [31:0]       inst_q, inst_d;
  logic              flush_pend_q, flush_pend_d;
  logic [TAG_W-1:0]  lat_tag_q, lat_tag_d;
  logic [IDX_W-1:0]  lat_idx_q, lat_idx_d;
  logic [OFF_W-1:0]  lat_off_q, lat_off_d;

  logic [63:0]       addr_ext;
  logic [OFF_W-1:0]  rq_off;
  logic [IDX_W-1:0]  rq_idx;
  logic [TAG_W-1:0]  rq_tag;
  logic [IDX_W-1:0]  rd_idx;
  logic [OFF_W-1:0]  rd_off;
  logic              rd_vld;
  logic [TAG_W-1:0]  rd_tag;
  logic [31:0]       rd_word;
  logic              idle, accept, hit, beat_ack, last_beat, arr_flush, valid_set;

  assign addr_ext = 64'(instAddr_i);
  assign rq_off   = OFF_W'(addr_field(addr_ext, 2, OFF_W));
  assign rq_idx   = IDX_W'(addr_field(addr_ext, 2 + OFF_W, IDX_W));
  assign rq_tag   = TAG_W'(addr_field(addr_ext, 2 + OFF_W + IDX_W, TAG_W));

  assign idle      = (state_q == ST_IDLE);
  assign accept    = idle && request_i && !dataok_q;
  // A flush in the lookup cycle wins: the lookup is forced to miss.
  assign hit       = rd_vld && (rd_tag == rq_tag) && !flush_i;
  assign beat_ack  = (state_q == ST_REFILL) && mem_req_q && mem_ack_i;
  assign last_beat = (beat_q == OFF_W'(WORDS_PER_LINE - 1));
  assign valid_set = !flush_pend_q && !flush_i;
  assign arr_flush = (idle && flush_i) || ((state_q == ST_RESP) && (flush_pend_q || flush_i));

  assign rd_idx = idle ? rq_idx : lat_idx_q;
  assign rd_off = idle ? rq_off : lat_off_q;

  icache_way0_array #(
    .LINES          (LINES),
    .WORDS_PER_LINE (WORDS_PER_LINE),
    .TAG_W          (TAG_W)
  ) u_array (
    .clk         (clk),
    .reset_n     (reset_n),
    .rd_idx_i    (rd_idx),
    .rd_off_i    (rd_off),
    .rd_vld_o    (rd_vld),
    .rd_tag_o    (rd_tag),
    .rd_word_o   (rd_word),
    .wr_en_i     (beat_ack),
    .wr_idx_i    (lat_idx_q),
    .wr_off_i    (beat_q),
    .wr_word_i   (mem_rdata_i),
    .tag_wr_i    (beat_ack && last_beat),
    .tag_i       (lat_tag_q),
    .valid_set_i (valid_set),
    .flush_i     (arr_flush)
  );

  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    dataok_d     = 1'b0;
    inst_d       = inst_q;
    flush_pend_d = flush_pend_q;
    lat_tag_d    = lat_tag_q;
    lat_idx_d    = lat_idx_q;
    lat_off_d    = lat_off_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (hit) begin
            dataok_d = 1'b1;
            inst_d   = rd_word;
          end else begin
            lat_tag_d    = rq_tag;
            lat_idx_d    = rq_idx;
            lat_off_d    = rq_off;
            beat_d       = '0;
            mem_req_d    = 1'b1;
            mem_addr_d   = {rq_tag, rq_idx, {OFF_W{1'b0}}, 2'b00};
            flush_pend_d = 1'b0;
            state_d      = ST_REFILL;
          end
        end
      end
      ST_REFILL: begin
        if (flush_i) begin
          flush_pend_d = 1'b1;
        end
        if (beat_ack) begin
          if (last_beat) begin
            mem_req_d = 1'b0;
            state_d   = ST_RESP;
          end else begin
            beat_d     = beat_q + OFF_W'(1);
            mem_addr_d = mem_addr_q + ADDR_W'(4);
          end
        end
      end
      ST_RESP: begin
        // The response pulse lands the cycle after RESP, already back in IDLE.
        dataok_d     = 1'b1;
        inst_d       = rd_word;
        flush_pend_d = 1'b0;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      beat_q       <= '0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      dataok_q     <= 1'b0;
      inst_q       <= '0;
      flush_pend_q <= 1'b0;
      lat_tag_q    <= '0;
      lat_idx_q    <= '0;
      lat_off_q    <= '0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      dataok_q     <= dataok_d;
      inst_q       <= inst_d;
      flush_pend_q <= flush_pend_d;
      lat_tag_q    <= lat_tag_d;
      lat_idx_q    <= lat_idx_d;
      lat_off_q    <= lat_off_d;
    end
  end

  assign dataOk_o   = dataok_q;
  assign inst_o     = inst_q;
  assign mem_req_o  = mem_req_q;
  assign mem_addr_o = mem_addr_q;
  assign busy_o     = !idle;

endmodule

// File: tb/tb_icache_way0.sv
// Directed bench for icache_way0: misses, hits, eviction, memory stalls, flush and reset mid-refill.
module tb_icache_way0;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        request_i;
  logic [31:0] instAddr_i;
  logic        flush_i;
  logic        dataOk_o;
  logic [31:0] inst_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i = 1'b0;
  logic [31:0] mem_rdata_i = 32'h0;
  logic        busy_o;

  int checks = 0;
  int errors = 0;

  icache_way0 dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .request_i   (request_i),
    .instAddr_i  (instAddr_i),
    .flush_i     (flush_i),
    .dataOk_o    (dataOk_o),
    .inst_o      (inst_o),
    .mem_req_o   (mem_req_o),
    .mem_addr_o  (mem_addr_o),
    .mem_ack_i   (mem_ack_i),
    .mem_rdata_i (mem_rdata_i),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  // Backing memory: word at address a holds 0xA000_0000 + line base + word number.
  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return 32'hA000_0000 + {a[31:4], 4'h0} + 32'(a[3:2]);
  endfunction

  int          gap = 0;
  int          beats = 0;
  int          wait_cnt = 0;
  int          stable_viol = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_addr = 32'h0;
  logic [31:0] addr_log [256];

  // Memory responder: acks after 'gap' idle request cycles, tracks address stability while stalled.
  always @(negedge clk) begin
    if (mem_req_o === 1'b1) begin
      if (prev_stall && (mem_addr_o !== prev_addr)) stable_viol++;
      prev_addr = mem_addr_o;
      if (wait_cnt >= gap) begin
        mem_ack_i   = 1'b1;
        mem_rdata_i = mem_data(mem_addr_o);
        if (beats < 256) addr_log[beats] = mem_addr_o;
        beats++;
        wait_cnt   = 0;
        prev_stall = 1'b0;
      end else begin
        mem_ack_i  = 1'b0;
        wait_cnt++;
        prev_stall = 1'b1;
      end
    end else begin
      mem_ack_i  = 1'b0;
      wait_cnt   = 0;
      prev_stall = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Called on a falling edge; returns the response word and cycles from acceptance to dataOk.
  task automatic fetch(input logic [31:0] addr, output logic [31:0] inst, output int cyc);
    bit got;
    got        = 1'b0;
    cyc        = -1;
    inst       = 32'hxxxx_xxxx;
    instAddr_i = addr;
    request_i  = 1'b1;
    for (int n = 1; n <= 200 && !got; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (dataOk_o === 1'b1) begin
        got  = 1'b1;
        cyc  = n;
        inst = inst_o;
      end
    end
    request_i = 1'b0;
    check("dataok_seen", 32'(got), 32'd1);
    @(posedge clk);
    @(negedge clk);
    check("dataok_single_pulse", 32'(dataOk_o), 32'd0);
  endtask

  logic [31:0] inst;
  int          cyc;
  int          s;
  bit          seen;

  initial begin
    reset_n    = 1'b0;
    request_i  = 1'b0;
    instAddr_i = 32'h0;
    flush_i    = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_dataok", 32'(dataOk_o), 32'd0);
    check("rst_inst", inst_o, 32'h0);
    check("rst_mem_req", 32'(mem_req_o), 32'd0);
    check("rst_mem_addr", mem_addr_o, 32'h0);
    check("rst_busy", 32'(busy_o), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Cold miss
    s = beats;
    fetch(32'h0000_0104, inst, cyc);
    check("cold_inst", inst, 32'hA000_0101);
    check("cold_latency", 32'(cyc), 32'd6);
    check("cold_beats", 32'(beats - s), 32'd4);
    for (int i = 0; i < 4; i++) check("cold_beat_addr", addr_log[s+i], 32'h100 + 32'(4*i));

    // Hit on the same line
    s = beats;
    fetch(32'h0000_0108, inst, cyc);
    check("hit_inst", inst, 32'hA000_0102);
    check("hit_latency", 32'(cyc), 32'd1);
    check("hit_no_beats", 32'(beats - s), 32'd0);

    // Conflict eviction on index 0
    s = beats;
    fetch(32'h0000_0500, inst, cyc);
    check("evict_inst", inst, 32'hA000_0500);
    check("evict_latency", 32'(cyc), 32'd6);
    check("evict_addr0", addr_log[s], 32'h500);
    fetch(32'h0000_0100, inst, cyc);
    check("refetch_inst", inst, 32'hA000_0100);
    check("refetch_latency", 32'(cyc), 32'd6);

    // Memory stalls: 3 idle cycles before each ack
    gap = 3;
    s = beats;
    fetch(32'h0000_03C8, inst, cyc);
    gap = 0;
    check("stall_inst", inst, 32'hA000_03C2);
    check("stall_latency", 32'(cyc), 32'd18);
    check("stall_beats", 32'(beats - s), 32'd4);
    check("stall_addr_stable", 32'(stable_viol), 32'd0);
    for (int i = 0; i < 4; i++) check("stall_beat_addr", addr_log[s+i], 32'h3C0 + 32'(4*i));
    fetch(32'h0000_03C4, inst, cyc);
    check("stall_line_hit_inst", inst, 32'hA000_03C1);
    check("stall_line_hit_latency", 32'(cyc), 32'd1);

    // Flush in IDLE, then the cached line misses
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    fetch(32'h0000_03C4, inst, cyc);
    check("idle_flush_inst", inst, 32'hA000_03C1);
    check("idle_flush_latency", 32'(cyc), 32'd6);

    // Flush in the lookup cycle forces a miss
    flush_i = 1'b1;
    fork
      fetch(32'h0000_03C4, inst, cyc);
      begin
        @(negedge clk);
        flush_i = 1'b0;
      end
    join
    check("same_cycle_flush_latency", 32'(cyc), 32'd6);

    // Flush during refill: response still delivered, line left invalid
    s = beats;
    seen = 1'b0;
    fork
      fetch(32'h0000_0104, inst, cyc);
      begin
        for (int n = 0; n < 100 && !seen; n++) begin
          @(negedge clk);
          #2;
          if (beats - s >= 2) seen = 1'b1;
        end
        if (seen) begin
          flush_i = 1'b1;
          @(negedge clk);
          #2;
          flush_i = 1'b0;
        end
      end
    join
    check("midflush_reached_beat1", 32'(seen), 32'd1);
    check("midflush_inst", inst, 32'hA000_0101);
    check("midflush_latency", 32'(cyc), 32'd6);
    fetch(32'h0000_0104, inst, cyc);
    check("midflush_refetch_latency", 32'(cyc), 32'd6);
    fetch(32'h0000_0108, inst, cyc);
    check("midflush_line_now_hits", 32'(cyc), 32'd1);

    // Reset after beat 2 of a refill
    s = beats;
    seen = 1'b0;
    instAddr_i = 32'h0000_03C8;
    request_i  = 1'b1;
    for (int n = 0; n < 100 && !seen; n++) begin
      @(negedge clk);
      #2;
      if (beats - s >= 3) seen = 1'b1;
    end
    check("rstmid_reached_beat2", 32'(seen), 32'd1);
    check("rstmid_busy_before", 32'(busy_o), 32'd1);
    check("rstmid_req_before", 32'(mem_req_o), 32'd1);
    reset_n = 1'b0;
    @(negedge clk);
    check("rstmid_mem_req", 32'(mem_req_o), 32'd0);
    check("rstmid_dataok", 32'(dataOk_o), 32'd0);
    check("rstmid_busy", 32'(busy_o), 32'd0);
    request_i = 1'b0;
    reset_n   = 1'b1;
    @(negedge clk);
    s = beats;
    fetch(32'h0000_03C8, inst, cyc);
    check("rstmid_refetch_latency", 32'(cyc), 32'd6);
    check("rstmid_refetch_inst", inst, 32'hA000_03C2);
    check("rstmid_refetch_beats", 32'(beats - s), 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/icache_way0.md
Name: icache_way0

Overview:
- Responder end of the way0 instruction-fetch interface: the instruction-memory side that answers the core's fetch request/address with a dataOk pulse and instruction word.
- Small direct-mapped instruction cache with flop-based tag/data arrays.
- Misses refill a full line over a simple word-beat memory read interface.
- Sits between the core's fetch port and the backing memory/bus.

Parameters:
- LINES, 16, number of cache lines (power of 2, >=2)
- WORDS_PER_LINE, 4, 32-bit words per line (power of 2, >=2)
- ADDR_W, 32, fetch/memory address width

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- request_i  in  1  core fetch request, held with address until dataOk_o
- instAddr_i  in  ADDR_W  fetch byte address; bits [1:0] ignored
- flush_i  in  1  single-cycle pulse, invalidate all lines
- dataOk_o  out  1  one-cycle pulse, inst_o valid
- inst_o  out  32  fetched instruction, held until next dataOk_o
- mem_req_o  out  1  memory beat request, held until mem_ack_i
- mem_addr_o  out  ADDR_W  word-aligned beat address
- mem_ack_i  in  1  beat complete, mem_rdata_i valid
- mem_rdata_i  in  32  beat data
- busy_o  out  1  high while not in IDLE

Behaviour:
- Reset (synchronous, reset_n=0 at clk edge):
  - all valid bits cleared; state IDLE.
  - dataOk_o=0, inst_o=0, mem_req_o=0, mem_addr_o=0, busy_o=0.
  - Tags and data are not reset.
  - Applies mid-refill: the in-flight beat is abandoned and mem_req_o drops the next cycle.
- Address split: offset = addr[2+OFF-1:2] with OFF=log2(WORDS_PER_LINE); index = next log2(LINES) bits; tag = remaining upper bits.
- States: IDLE, REFILL, RESP.
- Request acceptance: only in IDLE with request_i=1 and dataOk_o=0. One accepted fetch at most every 2 cycles; the cycle dataOk_o is high never re-accepts the still-asserted request.
- Hit (valid && tag match) accepted at cycle t: dataOk_o=1 and inst_o=data[index][offset] at t+1. Stay in IDLE.
- Miss accepted at t:
  - Latch tag/index/offset; go to REFILL.
  - mem_req_o=1 from t+1, mem_addr_o = {tag, index, beat=0, 2'b00}.
- REFILL:
  - Each cycle with mem_ack_i=1: write mem_rdata_i into data[index][beat].
  - If beat < WORDS_PER_LINE-1: beat++ and mem_addr_o += 4; mem_req_o stays high.
  - On the last ack: mem_req_o=0; write tag; set valid unless a flush is pending; go to RESP.
  - mem_ack_i while mem_req_o=0 is ignored.
- RESP (one cycle):
  - dataOk_o=1 with inst_o = the refilled word at the latched offset.
  - Return to IDLE.
  - Miss latency = WORDS_PER_LINE beat handshakes + 2 cycles.
- Address change during a miss (core jump): the refill still completes and responds for the latched address. The core discards that response; its new address is looked up on the next acceptance.
- Flush:
  - In IDLE: all valid bits cleared at that edge.
  - A lookup accepted in the same cycle as a flush is treated as a miss.
  - During REFILL/RESP: flush is latched as pending. It is applied when RESP exits, and the refilled line is left invalid; the RESP data is still returned.
- busy_o=1 in REFILL and RESP.

Decomposition:
- Package icache_way0_pkg: state enum (IDLE/REFILL/RESP), derived widths OFF_W/IDX_W/TAG_W as functions of the parameters, and address-field extraction functions.
- One natural sub-module, icache_way0_array: valid/tag/data flop storage.
  - Combinational read port (index, offset → valid, tag, word).
  - Line-word write port and tag/valid write.
  - Flush-all input.
- The FSM, beat counter and response register stay in the top.

Test Plan:
- Cold miss: reset, request_i=1, addr 0x0000_0104, memory acks every cycle returning 0xA000_0100+i for beats i=0..3 → mem_addr_o 0x100,0x104,0x108,0x10C; dataOk_o pulses once with inst_o=0xA000_0101, 6 cycles after acceptance.
- Hit: follow with addr 0x0000_0108 → dataOk_o at t+1, inst_o=0xA000_0102, mem_req_o stays 0.
- Conflict eviction (LINES=16, 4 words): fetch 0x100 then 0x500 (same index, different tag) → second is a refill; re-fetch 0x100 → refill again.
- Memory stalls: ack inserted with 3-cycle gaps → mem_req_o and mem_addr_o stay stable between acks; exactly 4 beats; a single dataOk_o.
- Flush mid-refill: flush_i pulsed at beat 1 → response still returned; a re-fetch of the same address misses. Flush in IDLE → next fetch of a cached line misses.
- Reset mid-refill: reset_n=0 after beat 2 → next cycle mem_req_o=0, dataOk_o=0, busy_o=0; subsequent fetch of that line misses.
